// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum state.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream (MSB first) and
// pulses word_valid combinationally on the byte that completes a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clear) begin
            idx_q   <= '0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[15:0], byte_in};
            idx_q   <= idx_q + 2'd1;
        end
    end

    assign word       = {shift_q, byte_in};
    assign word_valid = byte_valid && (idx_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a word-count header, writes big-endian words into
// instruction memory and holds the core in reset until the image is loaded.
// Optional trailing XOR checksum: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    loader_state_t state_q, state_d;
    logic          hdr_idx_q;
    logic [7:0]    hdr_hi_q;
    logic [15:0]   n_words_q;
    logic [15:0]   hdr_n;
    logic          xfer, restart, word_valid;
    logic [31:0]   packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    assign xfer    = in_valid && in_ready;
    assign hdr_n   = {hdr_hi_q, in_data};
    assign restart = start && (state_q == ST_DONE || state_q == ST_ERR);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (xfer && state_q == ST_LOAD),
        .byte_in    (in_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_HDR;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            ST_HDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && hdr_idx_q == 1'(HDR_BYTES - 1)) begin
                    if (hdr_n == 16'd0)        state_d = ST_DONE;
                    else if (hdr_n > DEPTH16)  state_d = ST_ERR;
                    else                       state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (word_valid && (word_cnt + 16'd1) == n_words_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                in_ready = 1'b1;
                if (xfer) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_d = ST_HDR;
            end
            ST_ERR: begin
                err = 1'b1;
                if (start) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_idx_q  <= 1'b0;
            hdr_hi_q   <= '0;
            n_words_q  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (xfer && state_q == ST_HDR) begin
                hdr_idx_q <= ~hdr_idx_q;
                if (!hdr_idx_q) hdr_hi_q  <= in_data;
                else            n_words_q <= hdr_n;
            end
            if (word_valid) begin
                imem_we    <= 1'b1;
                imem_wdata <= packed_word;
                imem_addr  <= word_cnt[ADDR_W-1:0];
                word_cnt   <= word_cnt + 16'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (xfer && (state_q == ST_HDR || state_q == ST_LOAD))
                csum_q <= csum_q ^ in_data;
`endif
            // Restart only happens from DONE/ERR, where no byte or word is in flight.
            if (restart) begin
                hdr_idx_q <= 1'b0;
                word_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_q    <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the MIPS core. It accepts a byte stream (valid/ready), assembles big-endian 32-bit instruction words, and writes them into instruction memory through its write port. It holds the core in reset until the full image is written, then releases it. It also reports load status for the testbench and the dump.

## Interface
- `DEPTH`, 32: instruction memory depth in words.
- `ADDR_W`, `$clog2(DEPTH)`: instruction memory address width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that restarts a load from DONE or ERR; ignored in other states.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `imem_we` output 1: instruction memory write strobe, one cycle per word.
- `imem_addr` output ADDR_W: word address of the write.
- `imem_wdata` output 32: instruction word.
- `cpu_reset` output 1: active-high reset to the MIPS core, matching the core's polarity.
- `busy` output 1: high in HDR or LOAD.
- `done` output 1: high in DONE.
- `err` output 1: high in ERR.
- `word_cnt` output 16: number of words written so far.

## Operation
- States are HDR, LOAD, CHK, DONE and ERR. CHK exists only when `IMEM_LOADER_CHECKSUM_EN` is defined.
- **HDR:** accept 2 bytes giving the word count N as a big-endian 16-bit value.
  - N == 0: go to DONE.
  - N > DEPTH: go to ERR.
  - Otherwise: go to LOAD.
- **LOAD:** accept bytes MSB first, 4 per word.
  - On the 4th byte of a word: register `imem_wdata`, `imem_addr = word_cnt[ADDR_W-1:0]` and `imem_we = 1`, then increment `word_cnt`.
  - After word N: go to CHK if the checksum feature is compiled in, else DONE.
- **CHK:** accept 1 byte.
  - Byte equals the running XOR of all header and payload bytes: go to DONE.
  - Otherwise: go to ERR.
- **DONE / ERR:** `in_ready = 0`.
  - `start` clears `word_cnt` and the byte index, re-asserts `cpu_reset`, and goes to HDR.
  - Memory contents are not cleared.
- `cpu_reset = 1` in every state except DONE.
- `in_ready = 1` in HDR, LOAD and CHK; it is a pure function of state.
- The byte index is a 2-bit wrap counter. `word_cnt` is 16 bits and never exceeds DEPTH.

## Timing
- Reset (`reset` low) forces: state HDR, `in_ready = 1`, `imem_we = 0`, `imem_addr = 0`, `imem_wdata = 0`, `cpu_reset = 1`, `busy = 1`, `done = 0`, `err = 0`, `word_cnt = 0`, checksum = 0.
- Reset takes effect asynchronously. A partial word or header is discarded.
- `imem_we` pulses high for exactly 1 cycle, in the cycle after the 4th byte of the word is accepted.
- The state transition out of LOAD happens in the same edge that raises `imem_we` for the final word.
- `cpu_reset` falls on the edge that enters DONE. For N words with no stall, this is 1 cycle after the last byte is accepted.
- `start` and `reset` asserted together: `reset` wins.
- `start` in HDR, LOAD or CHK: ignored, with no effect on state or counters.
- `in_valid` gaps: state holds, with no timeout.
- Minimum total load time is 2 + 4N (+1 with the checksum) accepted-byte cycles.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A trailing XOR checksum byte is required and verified in CHK.
  - A mismatch goes to ERR with `cpu_reset` held high.
- Not defined:
  - The CHK state and the XOR register are absent.
  - LOAD goes straight to DONE after word N.
  - No trailing byte is consumed.

## Structure
- `imem_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `HDR_BYTES = 2`;
  - `WORD_BYTES = 4`.
- Sub-module `byte_packer`: shifts in bytes MSB first and outputs a 32-bit word plus a `word_valid` pulse on the 4th byte. It has the same `clk` and `reset`.
- The top level holds the FSM, counters, checksum and output registers.

## Test plan
- Stream N=3 (`00 03`), then words 0x20080005, 0x20090003, 0x01095020, with no gaps:
  - writes occur to addr 0, 1 and 2 with those values, one `imem_we` each;
  - `cpu_reset` falls 1 cycle after the last byte;
  - `word_cnt = 3`.
- Header `00 00`: DONE is entered after 2 bytes, with no `imem_we` and `cpu_reset` low.
- Header `00 21` with DEPTH=32: ERR is entered, `in_ready = 0`, `cpu_reset` stays high, and no write occurs.
- Random `in_valid` gaps during a 2-word load: the written words and addresses are identical to the gap-free case.
- `reset` low for 1 cycle after 6 bytes of a 2-word load, then a fresh full image:
  - only the new image's words are written, starting at addr 0;
  - `word_cnt` ends at 2.
- With `IMEM_LOADER_CHECKSUM_EN`: image N=1, word 0x00000000.
  - Checksum 0x01 (correct): DONE.
  - Checksum 0x00: ERR. Then `start` returns to HDR with `cpu_reset = 1` and `word_cnt = 0`.
